// File: rtl/round_pipe_pkg.sv
// -----------------------------------------------------------------------------
// round_pkg
//
// Shared types and helpers for the divide/sqrt rounding unit (round_pipe).
//
//   rnd_mode_t : rounding mode selector (3 bits)
//                RNE - round to nearest, ties to even
//                RZ  - round toward zero (truncate magnitude)
//                RDN - round toward -infinity
//                RUP - round toward +infinity
//                RMM - round to nearest, ties away from zero
//   rem_t      : remainder status reported by the iteration engine
//                ZERO - estimate is exact down to the remainder
//                POS  - true value lies just above the estimate
//                NEG  - true value lies just below the estimate
//   rnd_dir_t  : what stage 2 does to the truncated magnitude
//                HOLD - keep T, INC - T + ULP step, DEC - T - ULP step
//
// The magnitude is always non-negative, so the directed modes collapse into
// two classes depending on the result sign: "toward" zero (shrink or keep the
// magnitude) and "away" from zero (grow the magnitude).
// -----------------------------------------------------------------------------
package round_pkg;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RZ  = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } rnd_mode_t;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        POS  = 2'd1,
        NEG  = 2'd2
    } rem_t;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        INC  = 2'd1,
        DEC  = 2'd2
    } rnd_dir_t;

    // Magnitude must not grow: RZ always, RUP on a negative result,
    // RDN on a positive result.
    function automatic logic mode_is_toward(input rnd_mode_t mode, input logic sign);
        return (mode == RZ) || (mode == RUP && sign) || (mode == RDN && !sign);
    endfunction

    // Magnitude must grow whenever the value is inexact: RUP on a positive
    // result, RDN on a negative result.
    function automatic logic mode_is_away(input rnd_mode_t mode, input logic sign);
        return (mode == RUP && !sign) || (mode == RDN && sign);
    endfunction

    // Nearest modes ignore the sign entirely.
    function automatic logic mode_is_nearest(input rnd_mode_t mode);
        return (mode == RNE) || (mode == RMM);
    endfunction

endpackage : round_pkg

// File: rtl/round_pipe_decide.sv
// -----------------------------------------------------------------------------
// round_decide
//
// Purely combinational rounding decision. Looks at the guard bits below the
// result LSB, the remainder status, the mode, the result sign and the result
// LSB, and tells stage 2 whether the truncated magnitude T is kept,
// incremented or decremented by one result ULP. Also reports whether the
// rounded value differs from the exact one.
//
// Ports
//   i_g       in  ULP : guard bits, in_x[ULP-1:0]
//   i_rem     in  2   : remainder status (rem_t)
//   i_mode    in  3   : rounding mode (rnd_mode_t)
//   i_sign    in  1   : result sign, only used by RUP/RDN
//   i_lsb     in  1   : result LSB in_x[ULP], used to break RNE ties
//   o_dir     out 2   : HOLD / INC / DEC (rnd_dir_t)
//   o_inexact out 1   : rounded result differs from the true value
// -----------------------------------------------------------------------------
module round_decide
    import round_pkg::*;
#(
    parameter int ULP = 4
) (
    input  logic [ULP-1:0] i_g,
    input  rem_t           i_rem,
    input  rnd_mode_t      i_mode,
    input  logic           i_sign,
    input  logic           i_lsb,
    output rnd_dir_t       o_dir,
    output logic           o_inexact
);

    // Half of one result ULP, expressed in guard-bit units.
    localparam logic [ULP-1:0] HALF = {1'b1, {(ULP-1){1'b0}}};

    logic w_g_zero;
    logic w_g_half;
    logic w_g_above_half;
    logic w_toward;
    logic w_away;
    logic w_nearest;

    assign w_g_zero       = (i_g == '0);
    assign w_g_half       = (i_g == HALF);
    assign w_g_above_half = (i_g > HALF);
    assign w_toward       = mode_is_toward(i_mode, i_sign);
    assign w_away         = mode_is_away(i_mode, i_sign);
    assign w_nearest      = mode_is_nearest(i_mode);

    always_comb begin
        o_dir     = HOLD;
        o_inexact = 1'b1;

        if (w_g_zero && i_rem == ZERO) begin
            // The estimate is the true value: nothing to round.
            o_dir     = HOLD;
            o_inexact = 1'b0;
        end else if (w_g_zero && i_rem == NEG) begin
            // True value sits just under T, i.e. in (T-ULP, T). Only the
            // toward class has to fall back to the previous step; every other
            // mode lands on T, which is either the nearest or the upper bound.
            o_dir = w_toward ? DEC : HOLD;
        end else if (w_toward) begin
            o_dir = HOLD;
        end else if (w_away) begin
            o_dir = INC;
        end else if (w_nearest) begin
            if (w_g_above_half || (w_g_half && i_rem == POS)) begin
                o_dir = INC;
            end else if (w_g_half && i_rem == ZERO) begin
                // Exact tie: RMM goes away from zero, RNE goes to the even
                // neighbour, which means incrementing only when T is odd.
                if (i_mode == RMM) begin
                    o_dir = INC;
                end else begin
                    o_dir = i_lsb ? INC : HOLD;
                end
            end else begin
                o_dir = HOLD;
            end
        end else begin
            // Unencoded mode values degrade to truncation so the unit never
            // produces an undefined direction.
            o_dir = HOLD;
        end
    end

endmodule : round_decide

// File: rtl/round_pipe.sv
// -----------------------------------------------------------------------------
// round_pipe
//
// Two-stage valid/ready rounding unit placed between the divide/sqrt iteration
// engine and result packing. Stage 1 captures the truncated magnitude T, the
// rounding direction and the exact flag; stage 2 applies the +/- one-ULP step,
// saturates on carry-out and registers the result with its flags and tag.
// Full throughput, backpressure from out_ready, results leave in order.
//
// Parameters
//   WIDTH : estimate/result width (includes the guard bits)
//   ULP   : number of guard bits below the result LSB (2 <= ULP < WIDTH)
//   TAG_W : width of the opaque tag carried with each operand
//
// Ports
//   clk          in  1     : clock
//   reset        in  1     : synchronous, active-high
//   in_valid     in  1     : operand presented
//   in_ready     out 1     : operand accepted this cycle
//   in_x         in  WIDTH : magnitude estimate including guard bits
//   in_rem       in  2     : remainder status (rem_t)
//   in_sign      in  1     : result sign (directed modes only)
//   in_mode      in  3     : rounding mode (rnd_mode_t)
//   in_tag       in  TAG_W : passed through unchanged
//   out_valid    out 1     : result presented
//   out_ready    in  1     : consumer accepts the result
//   out_y        out WIDTH : rounded magnitude, low ULP bits always zero
//   out_inexact  out 1     : result differs from the exact value
//   out_overflow out 1     : increment carried out, result saturated
//   out_tag      out TAG_W : tag of the result
// -----------------------------------------------------------------------------
module round_pipe
    import round_pkg::*;
#(
    parameter int WIDTH = 28,
    parameter int ULP   = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [1:0]       in_rem,
    input  logic             in_sign,
    input  logic [2:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_inexact,
    output logic             out_overflow,
    output logic [TAG_W-1:0] out_tag
);

    // Only the bits above the guard field carry information after rounding,
    // so T is held and stepped in result-ULP units.
    localparam int HI_W = WIDTH - ULP;

    // ------------------------------------------------------------------
    // Handshake: each stage advances when its downstream slot is free or
    // is being emptied this cycle. in_ready therefore depends on out_ready
    // combinationally, but out_valid is purely registered.
    // ------------------------------------------------------------------
    logic w_s1_en;
    logic w_s2_en;

    logic r_s1_valid;
    logic r_s2_valid;

    assign w_s2_en  = ~r_s2_valid | out_ready;
    assign w_s1_en  = ~r_s1_valid | w_s2_en;
    assign in_ready = w_s1_en;

    // ------------------------------------------------------------------
    // Rounding decision, ahead of the stage-1 register
    // ------------------------------------------------------------------
    rnd_dir_t w_dir;
    logic     w_inexact;

    round_decide #(
        .ULP (ULP)
    ) u_decide (
        .i_g       (in_x[ULP-1:0]),
        .i_rem     (rem_t'(in_rem)),
        .i_mode    (rnd_mode_t'(in_mode)),
        .i_sign    (in_sign),
        .i_lsb     (in_x[ULP]),
        .o_dir     (w_dir),
        .o_inexact (w_inexact)
    );

    // ------------------------------------------------------------------
    // Stage 1: truncated magnitude, direction, exact flag, tag
    // ------------------------------------------------------------------
    logic [HI_W-1:0]  r_s1_t;
    rnd_dir_t         r_s1_dir;
    logic             r_s1_exact;
    logic [TAG_W-1:0] r_s1_tag;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_t     <= '0;
            r_s1_dir   <= HOLD;
            r_s1_exact <= 1'b0;
            r_s1_tag   <= '0;
        end else if (w_s1_en) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_t     <= in_x[WIDTH-1:ULP];
                r_s1_dir   <= w_dir;
                r_s1_exact <= ~w_inexact;
                r_s1_tag   <= in_tag;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 datapath: one-step increment/decrement with saturation
    // ------------------------------------------------------------------
    logic [HI_W:0]   w_inc_sum;
    logic [HI_W-1:0] w_dec_diff;
    logic            w_t_zero;
    logic [HI_W-1:0] w_y_hi;
    logic            w_ovf;

    // Extra carry bit on the increment detects T+ULP spilling past WIDTH.
    assign w_inc_sum  = {1'b0, r_s1_t} + (HI_W+1)'(1);
    assign w_dec_diff = r_s1_t - HI_W'(1);
    assign w_t_zero   = (r_s1_t == '0);

    always_comb begin
        w_y_hi = r_s1_t;
        w_ovf  = 1'b0;
        unique case (r_s1_dir)
            INC: begin
                if (w_inc_sum[HI_W]) begin
                    // Saturate to the largest representable rounded value.
                    w_y_hi = '1;
                    w_ovf  = 1'b1;
                end else begin
                    w_y_hi = w_inc_sum[HI_W-1:0];
                end
            end
            DEC: begin
                // Stepping below zero cannot happen for a real quotient or
                // root; clamp at zero instead of wrapping.
                w_y_hi = w_t_zero ? '0 : w_dec_diff;
            end
            default: begin
                w_y_hi = r_s1_t;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stage 2 registers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_s2_y;
    logic             r_s2_inexact;
    logic             r_s2_overflow;
    logic [TAG_W-1:0] r_s2_tag;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_valid    <= 1'b0;
            r_s2_y        <= '0;
            r_s2_inexact  <= 1'b0;
            r_s2_overflow <= 1'b0;
            r_s2_tag      <= '0;
        end else if (w_s2_en) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_y        <= {w_y_hi, {ULP{1'b0}}};
                r_s2_inexact  <= ~r_s1_exact;
                r_s2_overflow <= w_ovf;
                r_s2_tag      <= r_s1_tag;
            end
        end
    end

    assign out_valid    = r_s2_valid;
    assign out_y        = r_s2_y;
    assign out_inexact  = r_s2_inexact;
    assign out_overflow = r_s2_overflow;
    assign out_tag      = r_s2_tag;

endmodule : round_pipe

// File: tb/tb_round_pipe.sv
// -----------------------------------------------------------------------------
// tb_round_pipe
//
// Directed and randomized checks of round_pipe at WIDTH=8, ULP=4, TAG_W=4.
// Expected results come either from literal values or from a reference model
// that rounds the true value (estimate nudged by the remainder sign) to the
// neighbouring multiples of 16 with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_round_pipe;
    import round_pkg::*;

    localparam int W  = 8;
    localparam int UL = 4;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_x = '0;
    logic [1:0]    in_rem = '0;
    logic          in_sign = 1'b0;
    logic [2:0]    in_mode = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_y;
    logic          out_inexact;
    logic          out_overflow;
    logic [TW-1:0] out_tag;

    round_pipe #(
        .WIDTH (W),
        .ULP   (UL),
        .TAG_W (TW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_x         (in_x),
        .in_rem       (in_rem),
        .in_sign      (in_sign),
        .in_mode      (in_mode),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_y        (out_y),
        .out_inexact  (out_inexact),
        .out_overflow (out_overflow),
        .out_tag      (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] y;
        logic       inex;
        logic       ovf;
        logic [3:0] tag;
    } exp_t;

    exp_t       sb[$];
    exp_t       cur_exp;
    int         total = 0;
    int         bad = 0;
    bit         acc_g;
    bit         stalled_prev = 1'b0;
    bit         saw_ready_low = 1'b0;
    logic [7:0] held_y;
    logic       held_inex;
    logic       held_ovf;
    logic [3:0] held_tag;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: true value scaled by 2 so the remainder becomes +/-1,
    // offset to stay positive; rounds to the multiples of 16 around it.
    function automatic exp_t model(input logic [7:0] x, input logic [1:0] rem,
                                   input logic sign, input logic [2:0] mode,
                                   input logic [3:0] tag);
        exp_t e;
        int   v2, lo, hi, mid, r;
        bit   exact;
        v2 = 2 * int'(x) + 1024;
        if (rem == POS) v2 += 1;
        else if (rem == NEG) v2 -= 1;
        exact = (v2 % 32) == 0;
        lo  = (v2 / 32) * 16 - 512;
        hi  = lo + 16;
        mid = 2 * lo + 16 + 1024;
        if (exact)              r = (v2 - 1024) / 2;
        else if (mode == RZ)    r = lo;
        else if (mode == RUP)   r = sign ? lo : hi;
        else if (mode == RDN)   r = sign ? hi : lo;
        else if (v2 > mid)      r = hi;
        else if (v2 < mid)      r = lo;
        else if (mode == RMM)   r = hi;
        else                    r = (((lo / 16) % 2) == 0) ? lo : hi;
        e.ovf = (r > 255);
        if (r > 255) r = 240;
        if (r < 0)   r = 0;
        e.y    = 8'(r);
        e.inex = !exact;
        e.tag  = tag;
        return e;
    endfunction

    task automatic drive(input logic [7:0] x, input logic [1:0] rem, input logic sign,
                         input logic [2:0] mode, input logic [3:0] tag);
        in_valid = 1'b1;
        in_x     = x;
        in_rem   = rem;
        in_sign  = sign;
        in_mode  = mode;
        in_tag   = tag;
        cur_exp  = model(x, rem, sign, mode, tag);
    endtask

    // One clock: sample handshakes at the falling edge, score, then step.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        chk("in_ready", in_ready, !(sb.size() == 2 && !out_ready));
        if (!in_ready) saw_ready_low = 1'b1;
        if (stalled_prev) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_y", out_y, held_y);
            chk("stall_inex", out_inexact, held_inex);
            chk("stall_ovf", out_overflow, held_ovf);
            chk("stall_tag", out_tag, held_tag);
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_out_valid", out_valid, 0);
            end else begin
                e = sb.pop_front();
                chk("out_y", out_y, e.y);
                chk("out_inexact", out_inexact, e.inex);
                chk("out_overflow", out_overflow, e.ovf);
                chk("out_tag", out_tag, e.tag);
                $display("xfer tag=%0h y=%02h inex=%0b ovf=%0b", out_tag, out_y, out_inexact, out_overflow);
            end
        end
        stalled_prev = out_valid && !out_ready;
        held_y    = out_y;
        held_inex = out_inexact;
        held_ovf  = out_overflow;
        held_tag  = out_tag;
        acc_g = in_valid && in_ready;
        if (acc_g) sb.push_back(cur_exp);
        @(posedge clk);
        #1;
    endtask

    // Directed vector with literal expected result.
    task automatic dvec(input logic [7:0] x, input logic [1:0] rem, input logic sign,
                        input logic [2:0] mode, input logic [3:0] tag,
                        input logic [7:0] ey, input logic ei, input logic eo);
        drive(x, rem, sign, mode, tag);
        cur_exp.y    = ey;
        cur_exp.inex = ei;
        cur_exp.ovf  = eo;
        cycle();
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() > 0 && n < 50) begin
            cycle();
            n++;
        end
        chk("drain_left", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, c;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_y", out_y, 0);
        chk("rst_inexact", out_inexact, 0);
        chk("rst_overflow", out_overflow, 0);
        chk("rst_tag", out_tag, 0);
        chk("rst_in_ready", in_ready, 1);

        // Latency of a single operand into an empty pipe
        dvec(8'h40, ZERO, 1'b0, RNE, 4'h1, 8'h40, 1'b0, 1'b0);
        in_valid = 1'b0;
        chk("lat_cycle1_valid", out_valid, 0);
        cycle();
        chk("lat_cycle2_valid", out_valid, 1);
        cycle();

        // Directed vectors, back to back
        dvec(8'h18, ZERO, 1'b0, RNE, 4'h0, 8'h20, 1'b1, 1'b0);
        dvec(8'h28, ZERO, 1'b0, RNE, 4'h1, 8'h20, 1'b1, 1'b0);
        dvec(8'h28, POS,  1'b0, RNE, 4'h2, 8'h30, 1'b1, 1'b0);
        dvec(8'h30, NEG,  1'b0, RZ,  4'h3, 8'h20, 1'b1, 1'b0);
        dvec(8'h30, NEG,  1'b0, RNE, 4'h4, 8'h30, 1'b1, 1'b0);
        dvec(8'h30, NEG,  1'b1, RUP, 4'h5, 8'h20, 1'b1, 1'b0);
        dvec(8'hF9, ZERO, 1'b0, RUP, 4'h6, 8'hF0, 1'b1, 1'b1);
        dvec(8'hF9, ZERO, 1'b1, RDN, 4'h7, 8'hF0, 1'b1, 1'b1);
        dvec(8'hF9, ZERO, 1'b0, RZ,  4'h8, 8'hF0, 1'b1, 1'b0);
        dvec(8'h40, ZERO, 1'b0, RNE, 4'h9, 8'h40, 1'b0, 1'b0);
        dvec(8'h40, ZERO, 1'b0, RZ,  4'hA, 8'h40, 1'b0, 1'b0);
        dvec(8'h40, ZERO, 1'b1, RDN, 4'hB, 8'h40, 1'b0, 1'b0);
        dvec(8'h40, ZERO, 1'b0, RUP, 4'hC, 8'h40, 1'b0, 1'b0);
        dvec(8'h40, ZERO, 1'b0, RMM, 4'hD, 8'h40, 1'b0, 1'b0);
        dvec(8'h00, NEG,  1'b0, RZ,  4'hE, 8'h00, 1'b1, 1'b0);
        dvec(8'h18, ZERO, 1'b0, RMM, 4'hF, 8'h20, 1'b1, 1'b0);
        dvec(8'h28, ZERO, 1'b0, RMM, 4'h0, 8'h30, 1'b1, 1'b0);
        dvec(8'h08, NEG,  1'b0, RNE, 4'h1, 8'h00, 1'b1, 1'b0);
        dvec(8'h09, NEG,  1'b0, RNE, 4'h2, 8'h10, 1'b1, 1'b0);
        dvec(8'h07, POS,  1'b0, RNE, 4'h3, 8'h00, 1'b1, 1'b0);
        dvec(8'hF8, ZERO, 1'b0, RNE, 4'h4, 8'hF0, 1'b1, 1'b1);
        dvec(8'h10, POS,  1'b1, RDN, 4'h5, 8'h20, 1'b1, 1'b0);
        drain();

        // Backpressure: 6 operands, out_ready low in cycles 3..6
        sent = 0;
        c = 0;
        saw_ready_low = 1'b0;
        while ((sent < 6 || sb.size() > 0) && c < 60) begin
            out_ready = !(c >= 3 && c <= 6);
            if (sent < 6) drive(8'($urandom), 2'($urandom_range(0, 2)), 1'($urandom),
                                3'($urandom_range(0, 4)), 4'(sent));
            else in_valid = 1'b0;
            cycle();
            if (acc_g) sent++;
            c++;
        end
        chk("bp_all_sent", sent, 6);
        chk("bp_ready_fell", saw_ready_low, 1);
        drain();

        // Randomized traffic with random backpressure
        for (int i = 0; i < 300; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0)
                drive(8'($urandom), 2'($urandom_range(0, 2)), 1'($urandom),
                      3'($urandom_range(0, 4)), 4'($urandom));
            else
                in_valid = 1'b0;
            cycle();
        end
        drain();

        // Reset with both stages full
        out_ready = 1'b0;
        drive(8'h55, POS, 1'b0, RNE, 4'h3);
        cycle();
        drive(8'h66, ZERO, 1'b0, RUP, 4'h4);
        cycle();
        in_valid = 1'b0;
        chk("full_out_valid", out_valid, 1);
        chk("full_in_ready", in_ready, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        stalled_prev = 1'b0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_y", out_y, 0);
        chk("midrst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        dvec(8'h18, ZERO, 1'b0, RNE, 4'h9, 8'h20, 1'b1, 1'b0);
        in_valid = 1'b0;
        chk("midrst_lat1_valid", out_valid, 0);
        cycle();
        chk("midrst_lat2_valid", out_valid, 1);
        cycle();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_round_pipe

// File: doc/round_pipe.md
# round_pipe

Parametrised, pipelined rounding unit that rounds the quotient and root estimates coming out of the iterative divide/sqrt datapath. It supports five IEEE-style rounding modes and uses the remainder sign to resolve sub-ULP position. It sits between the iteration engine and the result-packing logic. It has a two-stage valid/ready pipeline with full throughput and backpressure, and it reports inexact and overflow flags.

## Interface
- `WIDTH`, default 28: data width of the estimate and the result.
- `ULP`, default 4: number of guard bits below the result LSB. Must be ≥2 and <WIDTH.
- `TAG_W`, default 4: width of the opaque tag carried alongside each operand.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: an operand is presented.
- `in_ready` out 1: the unit accepts the operand this cycle.
- `in_x` in WIDTH: magnitude estimate, including the guard bits.
- `in_rem` in 2: remainder status, `rem_t`: ZERO, POS (true value > x), NEG (true value < x).
- `in_sign` in 1: sign of the result. Used only by the directed modes.
- `in_mode` in 3: rounding mode, `rnd_mode_t`: RNE, RZ, RDN, RUP, RMM.
- `in_tag` in TAG_W: passed through unchanged.
- `out_valid` out 1: a result is presented.
- `out_ready` in 1: the consumer accepts the result.
- `out_y` out WIDTH: rounded magnitude. The low ULP bits are always 0.
- `out_inexact` out 1: the result differs from the exact value.
- `out_overflow` out 1: increment carried out of WIDTH. The result is saturated.
- `out_tag` out TAG_W: tag of the result.

## Operation
- Notation:
  - T = in_x with the low ULP bits cleared.
  - G = in_x[ULP-1:0].
  - H = 1<<(ULP-1).
  - U = 1<<ULP.
- Rounding classes:
  - "away" class: RUP with sign=0, or RDN with sign=1.
  - "toward" class: RZ, RUP with sign=1, or RDN with sign=0.
- Below-floor case (G==0 and rem==NEG): the true value lies in (T−U, T).
  - toward class → T−U.
  - away, RNE and RMM → T.
  - inexact=1.
- Exact case (G==0 and rem==ZERO): y=T, inexact=0, in every mode.
- All other cases: inexact=1.
  - toward class → T.
  - away class → T+U.
  - Nearest modes, when G>H, or G==H with rem==POS → T+U.
  - Nearest modes, when G<H, or G==H with rem==NEG → T.
  - Tie (G==H and rem==ZERO): RNE rounds up iff in_x[ULP]==1; RMM always rounds up.
- Overflow: if T+U does not fit in WIDTH, then y = {all ones, ULP zeros} and overflow=1.
- Decrement from T==0 is a degenerate input: y=0, inexact=1, overflow=0.
- The tag is carried unchanged, and results leave in acceptance order.

## Timing
- Stage 1 registers T, the up/down/hold decision and the exact flag. Stage 2 registers y and the flags.
- Latency is 2 cycles from acceptance to out_valid, given out_ready=1. Throughput is 1 per cycle.
- Stage enables:
  - s2_en = ~s2_valid | out_ready.
  - s1_en = ~s1_valid | s2_en.
  - in_ready = s1_en, which is combinational from out_ready. There is no combinational path from in_valid to out_valid.
- A transfer occurs on valid&ready at the rising edge of clk.
- While out_valid=1 and out_ready=0, all out_* signals hold stable.
- When both stages are full and out_ready=0: in_ready=0, and nothing is dropped or duplicated.
- Reset:
  - All valids, out_y, flags and out_tag reset to 0.
  - in_ready reads 1 in the cycle after reset deasserts.
  - Asserting reset mid-stream discards all in-flight operands. No partial result appears.
- When the handshakes are simultaneous (s2 drains and s1 refills in the same cycle), the pipeline stays full and no bubble is inserted.

## Structure
- Package `round_pkg` holds:
  - `rnd_mode_t` (3-bit enum).
  - `rem_t` (2-bit enum: ZERO=0, POS=1, NEG=2).
  - `rnd_dir_t` (HOLD, INC, DEC).
- Sub-module `round_decide` is purely combinational. It maps (G, rem, mode, sign, lsb) to rnd_dir_t and inexact. It is instantiated once before the stage-1 register.
- The increment/decrement and saturation logic lives in stage 2 of round_pipe.

## Test plan
All scenarios use WIDTH=8, ULP=4.
- RNE ties:
  - x=0x18, rem ZERO → y=0x20, inexact=1.
  - x=0x28, rem ZERO → y=0x20, inexact=1.
  - x=0x28, rem POS → y=0x30.
- Below-floor: x=0x30, rem NEG.
  - RZ → y=0x20, inexact=1.
  - RNE → y=0x30, inexact=1.
  - RUP with sign=1 → y=0x20.
- Directed rounding and overflow:
  - x=0xF9, RUP, sign=0 → y=0xF0, overflow=1.
  - Same x with RDN, sign=1 → y=0xF0, overflow=1.
  - Same x with RZ → y=0xF0, overflow=0.
- Exact input: x=0x40, rem ZERO, every mode → y=0x40, inexact=0, overflow=0.
- Backpressure: stream 6 operands with tags 0–5 while holding out_ready=0 for cycles 3–6.
  - in_ready falls after 2 operands are held in the pipeline.
  - All 6 results emerge in tag order with correct values.
  - Outputs stay stable while stalled.
- Reset mid-stream: assert reset for 1 cycle with both stages full.
  - Next cycle: out_valid=0, out_y=0.
  - Then in_ready=1, and a new operand emerges 2 cycles after acceptance.
